// File: rtl/tact_debounce.sv
// Synchronises and debounces the active-low Tact1 button into a clean level plus press/release/long strobes.
// The auto-repeat strobe and its REPEAT_CYCLES parameter exist only when TACT_REPEAT_EN is defined.
module tact_debounce #(
    parameter int DB_CYCLES   = 240000,
    parameter int W_DB        = 18,
    parameter int LONG_CYCLES = 24000000,
    parameter int W_LONG      = 25
`ifdef TACT_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 4800000
`endif
) (
    input  logic CLK_24MHz,
    input  logic RST_N,
    input  logic Tact1,
    output logic TACT_LEVEL,
    output logic TACT_PRESS,
    output logic TACT_RELEASE,
    output logic TACT_LONG,
    output logic TACT_REPEAT
);

    typedef enum logic [2:0] {
        ST_RELEASED     = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_LONG_HELD    = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } state_t;

    localparam logic [W_DB-1:0]   DB_LAST   = W_DB'(DB_CYCLES - 1);
    localparam logic [W_LONG-1:0] LONG_LAST = W_LONG'(LONG_CYCLES - 1);

    state_t              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                pressed;
    logic [W_DB-1:0]     db_cnt_q, db_cnt_d;
    logic [W_LONG-1:0]   long_cnt_q, long_cnt_d;
    logic                long_held_q, long_held_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;

    always_comb begin
        sync1_d     = Tact1;
        sync2_d     = sync1_q;
        pressed     = ~sync2_q;
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        long_cnt_d  = long_cnt_q;
        long_held_d = long_held_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                db_cnt_d = '0;
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d  = ST_RELEASED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = ST_PRESSED;
                    press_d    = 1'b1;
                    db_cnt_d   = '0;
                    long_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + W_DB'(1);
                end
            end
            ST_PRESSED: begin
                // Reaching the long threshold wins; a simultaneous release still starts its wait.
                if (long_cnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                    if (!pressed) begin
                        state_d     = ST_RELEASE_WAIT;
                        db_cnt_d    = '0;
                        long_held_d = 1'b1;
                    end else begin
                        state_d = ST_LONG_HELD;
                    end
                end else begin
                    long_cnt_d = long_cnt_q + W_LONG'(1);
                    if (!pressed) begin
                        state_d     = ST_RELEASE_WAIT;
                        db_cnt_d    = '0;
                        long_held_d = 1'b0;
                    end
                end
            end
            ST_LONG_HELD: begin
                if (!pressed) begin
                    state_d     = ST_RELEASE_WAIT;
                    db_cnt_d    = '0;
                    long_held_d = 1'b1;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d  = long_held_q ? ST_LONG_HELD : ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + W_DB'(1);
                end
            end
            default: begin
                state_d     = ST_RELEASED;
                db_cnt_d    = '0;
                long_cnt_d  = '0;
                long_held_d = 1'b0;
            end
        endcase

        level_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD) ||
                  (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_RELEASED;
            db_cnt_q    <= '0;
            long_cnt_q  <= '0;
            long_held_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_held_q <= long_held_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign TACT_LEVEL   = level_q;
    assign TACT_PRESS   = press_q;
    assign TACT_RELEASE = release_q;
    assign TACT_LONG    = long_q;

`ifdef TACT_REPEAT_EN
    localparam int              W_RPT    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [W_RPT-1:0] RPT_LAST = W_RPT'(REPEAT_CYCLES - 1);

    logic [W_RPT-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             repeat_q, repeat_d;

    // Runs only while long-held, holds through a release wait, clears once the release is accepted.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        repeat_d  = 1'b0;
        if (state_q == ST_LONG_HELD) begin
            if (rpt_cnt_q == RPT_LAST) begin
                rpt_cnt_d = '0;
                repeat_d  = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + W_RPT'(1);
            end
        end
        if (state_d == ST_RELEASED) begin
            rpt_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign TACT_REPEAT = repeat_q;
`else
    assign TACT_REPEAT = 1'b0;
`endif

endmodule

// File: tb/tb_tact_debounce.sv
// Bench for tact_debounce: directed latency/bounce/long-press scenarios plus randomized button activity,
// all checked every cycle against a run-length reference model.
module tb_tact_debounce;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int RPT  = 8;

    logic clock = 1'b0;
    logic RST_N = 1'b0;
    logic Tact1 = 1'b0;
    logic TACT_LEVEL, TACT_PRESS, TACT_RELEASE, TACT_LONG, TACT_REPEAT;

    int checks   = 0;
    int failures = 0;

    logic hist1, hist2;
    logic m_level, m_long_fired;
    int   m_run, m_press_time, m_rpt_time;
    logic exp_level, exp_press, exp_release, exp_long, exp_repeat;

    int   cyc, press_cnt, press_at, release_cnt, release_at, long_cnt, long_at;
    int   level_fall_cnt, level_fall_at;
    int   repeat_at[$];
    logic prev_level = 1'b0;
    logic bounce_seq [6];

    always #5 clock = ~clock;

    tact_debounce #(
        .DB_CYCLES(DB),
        .W_DB(18),
        .LONG_CYCLES(LONG),
        .W_LONG(25)
`ifdef TACT_REPEAT_EN
        ,
        .REPEAT_CYCLES(RPT)
`endif
    ) dut (
        .CLK_24MHz(clock),
        .RST_N(RST_N),
        .Tact1(Tact1),
        .TACT_LEVEL(TACT_LEVEL),
        .TACT_PRESS(TACT_PRESS),
        .TACT_RELEASE(TACT_RELEASE),
        .TACT_LONG(TACT_LONG),
        .TACT_REPEAT(TACT_REPEAT)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: observed %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        hist1        = 1'b1;
        hist2        = 1'b1;
        m_level      = 1'b0;
        m_long_fired = 1'b0;
        m_run        = 0;
        m_press_time = 0;
        m_rpt_time   = 0;
        exp_level    = 1'b0;
        exp_press    = 1'b0;
        exp_release  = 1'b0;
        exp_long     = 1'b0;
        exp_repeat   = 1'b0;
    endtask

    // The accepted level flips after DB+1 consecutive synchronised samples disagree with it;
    // hold time only accrues on pressed cycles with no release pending.
    task automatic modelStep(input logic raw);
        logic s;
        int   run_before;
        s           = ~hist2;
        hist2       = hist1;
        hist1       = raw;
        exp_press   = 1'b0;
        exp_release = 1'b0;
        exp_long    = 1'b0;
        exp_repeat  = 1'b0;
        run_before  = m_run;
        if (m_level && run_before == 0) begin
            if (!m_long_fired) begin
                m_press_time++;
                if (m_press_time == LONG) begin
                    exp_long     = 1'b1;
                    m_long_fired = 1'b1;
                end
            end else begin
                m_rpt_time++;
                if (m_rpt_time == RPT) begin
`ifdef TACT_REPEAT_EN
                    exp_repeat = 1'b1;
`endif
                    m_rpt_time = 0;
                end
            end
        end
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == DB + 1) begin
            m_level = s;
            m_run   = 0;
            if (s) begin
                exp_press    = 1'b1;
                m_press_time = 0;
                m_long_fired = 1'b0;
            end else begin
                exp_release = 1'b1;
                m_rpt_time  = 0;
            end
        end
        exp_level = m_level;
    endtask

    task automatic clearEvents();
        cyc            = 0;
        press_cnt      = 0;
        press_at       = -1;
        release_cnt    = 0;
        release_at     = -1;
        long_cnt       = 0;
        long_at        = -1;
        level_fall_cnt = 0;
        level_fall_at  = -1;
        repeat_at.delete();
    endtask

    task automatic applyStimulus(input logic rst_val, input logic tact_val);
        @(negedge clock);
        RST_N = rst_val;
        Tact1 = tact_val;
        @(posedge clock);
        if (!rst_val) modelReset();
        else modelStep(tact_val);
        #1;
        checkOutput("level",   int'(TACT_LEVEL),   int'(exp_level));
        checkOutput("press",   int'(TACT_PRESS),   int'(exp_press));
        checkOutput("release", int'(TACT_RELEASE), int'(exp_release));
        checkOutput("long",    int'(TACT_LONG),    int'(exp_long));
        checkOutput("repeat",  int'(TACT_REPEAT),  int'(exp_repeat));
        if (TACT_PRESS) begin press_cnt++; press_at = cyc; end
        if (TACT_RELEASE) begin release_cnt++; release_at = cyc; end
        if (TACT_LONG) begin long_cnt++; long_at = cyc; end
        if (TACT_REPEAT) repeat_at.push_back(cyc);
        if (prev_level && !TACT_LEVEL) begin level_fall_cnt++; level_fall_at = cyc; end
        prev_level = TACT_LEVEL;
        cyc++;
    endtask

    task automatic releaseButton();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
    endtask

    initial begin
        logic val;
        int   len;
        modelReset();
        clearEvents();
        bounce_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held with the button pressed
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("reset_level",   int'(TACT_LEVEL),   0);
        checkOutput("reset_press",   int'(TACT_PRESS),   0);
        checkOutput("reset_release", int'(TACT_RELEASE), 0);
        checkOutput("reset_long",    int'(TACT_LONG),    0);
        checkOutput("reset_repeat",  int'(TACT_REPEAT),  0);

        // Out of reset still held, 40 cycles with a 2-cycle high glitch at cycle 30
        clearEvents();
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, (i == 30 || i == 31));
        checkOutput("first_press_at",  press_at, 6);
        checkOutput("first_press_cnt", press_cnt, 1);
        checkOutput("long_at",         long_at, 26);
        checkOutput("long_once",       long_cnt, 1);
        checkOutput("no_release_glitch", release_cnt, 0);
        checkOutput("level_held",      int'(TACT_LEVEL), 1);

        // Clean release
        clearEvents();
        releaseButton();
        checkOutput("release_at",      release_at, 6);
        checkOutput("release_cnt",     release_cnt, 1);
        checkOutput("level_fall_at",   level_fall_at, 6);
        checkOutput("no_press_on_rel", press_cnt, 0);

        // Bounce on press: accepted 6 cycles after the last 1->0 (index 5)
        clearEvents();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, (i < 6) ? bounce_seq[i] : 1'b0);
        checkOutput("bounce_press_at",  press_at, 11);
        checkOutput("bounce_press_cnt", press_cnt, 1);
        releaseButton();

        // 3-cycle release glitch while pressed delays the long strobe by 3
        clearEvents();
        for (int i = 0; i < 35; i++) applyStimulus(1'b1, (i >= 10 && i <= 12));
        checkOutput("glitch_press_at",   press_at, 6);
        checkOutput("glitch_long_at",    long_at, 29);
        checkOutput("glitch_no_release", release_cnt, 0);
        checkOutput("glitch_level_kept", level_fall_cnt, 0);
        releaseButton();

        // Long hold for auto-repeat
        clearEvents();
        for (int i = 0; i < 55; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("hold_long_at", long_at, 26);
`ifdef TACT_REPEAT_EN
        checkOutput("repeat_count", repeat_at.size(), 3);
        checkOutput("repeat_first", (repeat_at.size() > 0) ? repeat_at[0] : -1, 34);
        checkOutput("repeat_second", (repeat_at.size() > 1) ? repeat_at[1] : -1, 42);
        checkOutput("repeat_third", (repeat_at.size() > 2) ? repeat_at[2] : -1, 50);
`else
        checkOutput("repeat_count", repeat_at.size(), 0);
`endif
        releaseButton();

        // Randomized runs of short bounces and long holds with occasional resets
        val = 1'b1;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)));
                applyStimulus(1'b0, 1'($urandom_range(0, 1)));
            end
            val = ($urandom_range(0, 3) == 0) ? val : ~val;
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 45)) : int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) applyStimulus(1'b1, val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
